// File: rtl/rob_phase_sync.sv
// Commit-side phase barrier for base/variant differential simulation: stalls the
// core that reaches a phase marker first until its twin commits the same marker.
module rob_phase_sync #(
  parameter int TIMEOUT = 4096,
  parameter int CW      = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          base_valid,
  input  logic [31:0]   base_inst,
  input  logic          var_valid,
  input  logic [31:0]   var_inst,
  input  logic          resync,
  output logic          stall_base,
  output logic          stall_var,
  output logic          sync,
  output logic          evt_valid,
  output logic [3:0]    evt_code,
  output logic [1:0]    evt_src,
  output logic [2:0]    phase,
  output logic          in_phase,
  output logic          mismatch,
  output logic          timeout,
  output logic          proto_err,
  output logic [CW-1:0] skew_max
);
  typedef enum logic [1:0] {RUN, WAIT_V, WAIT_B, DESYNC} state_t;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  state_t        r_state, w_nxt;
  logic [3:0]    r_code;
  logic [CW-1:0] r_timer;
  logic          r_hold_vld;
  logic [3:0]    r_hold_code;
  logic          r_evt_valid;
  logic [3:0]    r_evt_code;
  logic [1:0]    r_evt_src;
  logic [2:0]    r_phase;
  logic          r_in_phase;
  logic          r_mismatch, r_timeout, r_proto_err;
  logic [CW-1:0] r_skew;

  logic          w_bm, w_vm, w_wait, w_pair, w_mis, w_tmo_hit, w_perr, w_end_bad;
  logic [3:0]    w_bcode, w_vcode, w_pcode;
  logic [CW-1:0] w_timer_inc;

  assign w_bcode = base_inst[23:20];
  assign w_vcode = var_inst[23:20];
  assign w_bm    = base_valid && base_inst[19:0] == 20'h02013 && base_inst[31:24] == 8'h00
                   && w_bcode <= 4'd13;
  assign w_vm    = var_valid && var_inst[19:0] == 20'h02013 && var_inst[31:24] == 8'h00
                   && w_vcode <= 4'd13;

  assign w_wait      = (r_state == WAIT_V) || (r_state == WAIT_B);
  assign w_timer_inc = (&r_timer) ? r_timer : r_timer + CW'(1);

  // A late marker wins over a timeout expiring in the same cycle.
  assign w_pair    = (r_state == RUN    && w_bm && w_vm && w_bcode == w_vcode)
                  || (r_state == WAIT_V && w_vm && w_vcode == r_code)
                  || (r_state == WAIT_B && w_bm && w_bcode == r_code);
  assign w_mis     = (r_state == RUN    && w_bm && w_vm && w_bcode != w_vcode)
                  || (r_state == WAIT_V && w_vm && w_vcode != r_code)
                  || (r_state == WAIT_B && w_bm && w_bcode != r_code);
  assign w_tmo_hit = (r_state == WAIT_V && !w_vm && r_timer == TMO_LAST)
                  || (r_state == WAIT_B && !w_bm && r_timer == TMO_LAST);
  assign w_pcode   = (r_state == RUN) ? w_bcode : r_code;
  assign w_end_bad = w_pcode[0] && (w_pcode[3:1] != r_phase);
  assign w_perr    = (r_state == WAIT_V && base_valid)
                  || (r_state == WAIT_B && var_valid)
                  || (w_pair && w_end_bad)
                  || (r_state == DESYNC && w_bm && w_vm && r_hold_vld);

  always_ff @(posedge clock) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      RUN: begin
        if (w_mis)     w_nxt = DESYNC;
        else if (w_pair) w_nxt = RUN;
        else if (w_bm) w_nxt = WAIT_V;
        else if (w_vm) w_nxt = WAIT_B;
      end
      WAIT_V, WAIT_B: begin
        if (w_pair)                 w_nxt = RUN;
        else if (w_mis || w_tmo_hit) w_nxt = DESYNC;
      end
      DESYNC: if (resync) w_nxt = RUN;
      default: w_nxt = RUN;
    endcase
  end

  always_comb begin
    stall_base = 1'b0;
    stall_var  = 1'b0;
    sync       = 1'b1;
    unique case (r_state)
      WAIT_V:  stall_base = 1'b1;
      WAIT_B:  stall_var  = 1'b1;
      DESYNC:  sync       = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_code      <= '0;
      r_timer     <= '0;
      r_hold_vld  <= 1'b0;
      r_hold_code <= '0;
      r_evt_valid <= 1'b0;
      r_evt_code  <= '0;
      r_evt_src   <= '0;
      r_phase     <= '0;
      r_in_phase  <= 1'b0;
      r_mismatch  <= 1'b0;
      r_timeout   <= 1'b0;
      r_proto_err <= 1'b0;
      r_skew      <= '0;
    end else begin
      r_evt_valid <= 1'b0;
      if (w_wait) r_timer <= w_timer_inc;
      if (r_state == RUN && (w_bm ^ w_vm)) begin
        r_code  <= w_bm ? w_bcode : w_vcode;
        r_timer <= '0;
      end
      if (w_pair) begin
        r_evt_valid <= 1'b1;
        r_evt_code  <= w_pcode;
        r_evt_src   <= 2'b11;
        if (!w_pcode[0]) begin
          r_phase    <= w_pcode[3:1];
          r_in_phase <= 1'b1;
        end else if (!w_end_bad) begin
          r_in_phase <= 1'b0;
        end
        if (w_wait && w_timer_inc > r_skew) r_skew <= w_timer_inc;
      end
      if (w_mis)     r_mismatch  <= 1'b1;
      if (w_tmo_hit) r_timeout   <= 1'b1;
      if (w_perr)    r_proto_err <= 1'b1;
      // Pass-through: base reported first, a simultaneous variant marker waits one cycle.
      if (r_state == DESYNC) begin
        if (w_bm) begin
          r_evt_valid <= 1'b1;
          r_evt_code  <= w_bcode;
          r_evt_src   <= 2'b01;
          if (w_vm) begin
            r_hold_vld  <= 1'b1;
            r_hold_code <= w_vcode;
          end
        end else if (r_hold_vld) begin
          r_evt_valid <= 1'b1;
          r_evt_code  <= r_hold_code;
          r_evt_src   <= 2'b10;
          r_hold_vld  <= w_vm;
          r_hold_code <= w_vcode;
        end else if (w_vm) begin
          r_evt_valid <= 1'b1;
          r_evt_code  <= w_vcode;
          r_evt_src   <= 2'b10;
        end
        if (resync) r_hold_vld <= 1'b0;
      end
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_code  = r_evt_code;
  assign evt_src   = r_evt_src;
  assign phase     = r_phase;
  assign in_phase  = r_in_phase;
  assign mismatch  = r_mismatch;
  assign timeout   = r_timeout;
  assign proto_err = r_proto_err;
  assign skew_max  = r_skew;
endmodule

// File: tb/tb_rob_phase_sync.sv
// Directed plus randomized bench for rob_phase_sync against a cycle-count /
// queue based reference model of the barrier rules.
module tb_rob_phase_sync;
  localparam int TO = 8;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset, base_valid, var_valid, resync;
  logic [31:0]   base_inst, var_inst;
  logic          stall_base, stall_var, sync, evt_valid;
  logic [3:0]    evt_code;
  logic [1:0]    evt_src;
  logic [2:0]    phase;
  logic          in_phase, mismatch, timeout, proto_err;
  logic [CW-1:0] skew_max;

  always #5 clock = ~clock;

  rob_phase_sync #(.TIMEOUT(TO), .CW(CW)) dut (
    .clock(clock), .reset(reset),
    .base_valid(base_valid), .base_inst(base_inst),
    .var_valid(var_valid), .var_inst(var_inst), .resync(resync),
    .stall_base(stall_base), .stall_var(stall_var), .sync(sync),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_src(evt_src),
    .phase(phase), .in_phase(in_phase), .mismatch(mismatch),
    .timeout(timeout), .proto_err(proto_err), .skew_max(skew_max)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who is waiting, since which cycle, and a pending-variant queue.
  int cyc = 0;
  int m_wait = 0;
  bit m_des = 0;
  int m_code = 0, m_t0 = 0;
  bit m_ev = 0;
  int m_ec = 0, m_es = 0, m_ph = 0, m_skew = 0;
  bit m_inp = 0, m_mis = 0, m_tmo = 0, m_perr = 0;
  int m_q[$];

  function automatic logic [31:0] mk(input int c);
    return {8'h00, 4'(c), 20'h02013};
  endfunction

  function automatic int mcode(input logic v, input logic [31:0] i);
    if (v && i[19:0] == 20'h02013 && i[31:24] == 8'h00 && i[23:20] <= 4'd13)
      return int'(i[23:20]);
    return -1;
  endfunction

  task automatic emit(input int c, input int s);
    m_ev = 1; m_ec = c; m_es = s;
  endtask

  task automatic pair(input int c, input int s);
    emit(c, 3);
    if (c % 2 == 0) begin m_ph = c / 2; m_inp = 1; end
    else if (c / 2 == m_ph) m_inp = 0;
    else m_perr = 1;
    if (s > m_skew) m_skew = s;
  endtask

  task automatic model(input logic bv, input logic [31:0] bi, input logic vv,
                       input logic [31:0] vi, input logic rs, input logic rst);
    int bc, vc, oc;
    bit stv;
    bc = mcode(bv, bi);
    vc = mcode(vv, vi);
    if (rst) begin
      m_wait = 0; m_des = 0; m_ev = 0; m_ec = 0; m_es = 0; m_ph = 0; m_inp = 0;
      m_mis = 0; m_tmo = 0; m_perr = 0; m_skew = 0; m_q.delete();
    end else begin
      m_ev = 0;
      if (m_des) begin
        if (bc >= 0) begin
          emit(bc, 1);
          if (vc >= 0) begin
            if (m_q.size() != 0) begin m_perr = 1; m_q.delete(); end
            m_q.push_back(vc);
          end
        end else if (m_q.size() != 0) begin
          emit(m_q.pop_front(), 2);
          if (vc >= 0) m_q.push_back(vc);
        end else if (vc >= 0) emit(vc, 2);
        if (rs) begin m_des = 0; m_q.delete(); end
      end else if (m_wait == 0) begin
        if (bc >= 0 && vc >= 0) begin
          if (bc == vc) pair(bc, 0);
          else begin m_mis = 1; m_des = 1; end
        end else if (bc >= 0) begin m_wait = 1; m_code = bc; m_t0 = cyc; end
        else if (vc >= 0) begin m_wait = 2; m_code = vc; m_t0 = cyc; end
      end else begin
        oc  = (m_wait == 1) ? vc : bc;
        stv = (m_wait == 1) ? bv : vv;
        if (stv) m_perr = 1;
        if (oc >= 0) begin
          if (oc == m_code) pair(oc, cyc - m_t0);
          else begin m_mis = 1; m_des = 1; end
          m_wait = 0;
        end else if (cyc - m_t0 == TO) begin
          m_tmo = 1; m_des = 1; m_wait = 0;
        end
      end
    end
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("stall_base", 32'(stall_base), 32'(m_wait == 1));
    chk("stall_var",  32'(stall_var),  32'(m_wait == 2));
    chk("sync",       32'(sync),       32'(!m_des));
    chk("evt_valid",  32'(evt_valid),  32'(m_ev));
    chk("evt_code",   32'(evt_code),   32'(m_ec));
    chk("evt_src",    32'(evt_src),    32'(m_es));
    chk("phase",      32'(phase),      32'(m_ph));
    chk("in_phase",   32'(in_phase),   32'(m_inp));
    chk("mismatch",   32'(mismatch),   32'(m_mis));
    chk("timeout",    32'(timeout),    32'(m_tmo));
    chk("proto_err",  32'(proto_err),  32'(m_perr));
    chk("skew_max",   32'(skew_max),   32'(m_skew));
  endtask

  task automatic step(input logic bv, input logic [31:0] bi, input logic vv,
                      input logic [31:0] vi, input logic rs, input logic rst);
    base_valid = bv; base_inst = bi; var_valid = vv; var_inst = vi;
    resync = rs; reset = rst;
    model(bv, bi, vv, vi, rs, rst);
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] gen(input int pref);
    int r;
    r = $urandom_range(0, 9);
    if (pref >= 0 && r < 4) return mk(pref);
    if (r < 6) return mk($urandom_range(0, 13));
    if (r == 6) return mk($urandom_range(14, 15));
    if (r == 7) return {8'h01, 4'($urandom_range(0, 13)), 20'h02013};
    return $urandom();
  endfunction

  initial begin
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("rst_sync", 32'(sync), 32'd1);
    chk("rst_evt",  32'({evt_valid, evt_code, evt_src}), 32'd0);
    idle(2);

    // Base-first barrier, five cycle skew.
    step(1'b1, mk(0), 1'b0, 32'h0, 1'b0, 1'b0);
    chk("tp1_stall", 32'(stall_base), 32'd1);
    idle(4);
    step(1'b0, 32'h0, 1'b1, mk(0), 1'b0, 1'b0);
    chk("tp1_src",  32'(evt_src), 32'd3);
    chk("tp1_skew", 32'(skew_max), 32'd5);
    chk("tp1_inph", 32'(in_phase), 32'd1);

    // Same-cycle pair.
    step(1'b1, 32'h00402013, 1'b1, 32'h00402013, 1'b0, 1'b0);
    chk("tp2_code",  32'(evt_code), 32'd4);
    chk("tp2_phase", 32'(phase), 32'd2);
    chk("tp2_skew",  32'(skew_max), 32'd5);

    // Variant-first barrier, END of phase 2.
    step(1'b0, 32'h0, 1'b1, mk(5), 1'b0, 1'b0);
    chk("wb_stall", 32'(stall_var), 32'd1);
    idle(1);
    step(1'b1, mk(5), 1'b0, 32'h0, 1'b0, 1'b0);
    chk("wb_inph", 32'(in_phase), 32'd0);

    // Mismatch into DESYNC, then pass-through events.
    step(1'b1, 32'h00602013, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 32'h00802013, 1'b0, 1'b0);
    chk("tp3_mis",  32'(mismatch), 32'd1);
    chk("tp3_sync", 32'(sync), 32'd0);
    step(1'b1, mk(5), 1'b0, 32'h0, 1'b0, 1'b0);
    chk("tp3_src", 32'(evt_src), 32'd1);
    step(1'b1, mk(2), 1'b1, mk(3), 1'b0, 1'b0);
    chk("tp6_a", 32'({evt_valid, evt_code, evt_src}), 32'({1'b1, 4'd2, 2'b01}));
    idle(1);
    chk("tp6_b", 32'({evt_valid, evt_code, evt_src}), 32'({1'b1, 4'd3, 2'b10}));
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("rs_sync", 32'(sync), 32'd1);

    // Timeout with silent variant.
    step(1'b1, mk(0), 1'b0, 32'h0, 1'b0, 1'b0);
    idle(TO - 1);
    chk("tp4_pre", 32'(sync), 32'd1);
    idle(1);
    chk("tp4_tmo", 32'({timeout, sync}), 32'({1'b1, 1'b0}));
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("tp4_rs", 32'({timeout, sync}), 32'({1'b1, 1'b1}));

    // Protocol error while stalled, then reset mid-wait.
    step(1'b1, mk(2), 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, mk(4), 1'b0, 32'h0, 1'b0, 1'b0);
    chk("tp5_perr", 32'({proto_err, stall_base}), 32'({1'b1, 1'b1}));
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("tp5_rst", 32'({stall_base, proto_err, timeout, mismatch, sync}), 32'd1);

    for (int k = 0; k < 3000; k++) begin
      logic bv, vv, rs, rst;
      logic [31:0] bi, vi;
      int pb, pv;
      pb  = (m_wait == 2) ? m_code : -1;
      pv  = (m_wait == 1) ? m_code : -1;
      bv  = (m_wait == 1) ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 2) == 0);
      vv  = (m_wait == 2) ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 2) == 0);
      bi  = gen(pb);
      vi  = gen(pv);
      rs  = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 499) == 0);
      step(bv, bi, vv, vi, rs, rst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rob_phase_sync.md
# rob_phase_sync

Commit-side barrier controller for the dual-core (base/variant) differential simulation. It watches each core's ROB commit stream for phase-marker instructions (`slti x0,x0,imm`). Whenever one core commits a marker, it stalls that core's commit until the other core commits the same marker. This keeps both cores phase-aligned, and it emits a single paired event per phase boundary for the taint/event loggers. Mismatched or overdue markers drop the block into a desynchronised pass-through mode and raise sticky flags.

## Interface
- `TIMEOUT`, 4096: wait cycles before a barrier is abandoned; must be ≥2.
- `CW`, 16: width of the wait timer and `skew_max`.
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `base_valid`  in  1  base core commits an instruction this cycle.
- `base_inst`  in  32  encoding of that instruction.
- `var_valid`  in  1  variant core commits an instruction.
- `var_inst`  in  32  encoding of that instruction.
- `resync`  in  1  one-cycle pulse: leave DESYNC and return to RUN.
- `stall_base`  out  1  hold base commit; the core honours it in the same cycle.
- `stall_var`  out  1  hold variant commit.
- `sync`  out  1  high while cores are barrier-aligned.
- `evt_valid`  out  1  one-cycle event pulse.
- `evt_code`  out  4  marker code, 0..13.
- `evt_src`  out  2  bit0 = base, bit1 = variant; 2'b11 = paired.
- `phase`  out  3  last started phase (code>>1).
- `in_phase`  out  1  START seen, matching END not yet seen.
- `mismatch`, `timeout`, `proto_err`  out  1 each  sticky error flags.
- `skew_max`  out  CW  largest barrier wait observed, in cycles.

## Operation
- **Marker detection:** `inst[19:0]==20'h02013`, `inst[31:24]==0` and `inst[23:20]<=13`. The code is `inst[23:20]`. `code[0]==0` means START, `1` means END. `phase = code>>1`. A marker counts only when its valid input is high.
- **FSM states:** RUN, WAIT_V (base arrived first), WAIT_B (variant arrived first), DESYNC.
- **RUN:**
  - Markers from both cores in the same cycle with equal codes → paired event; stay in RUN.
  - Both cores, unequal codes → set `mismatch`; go to DESYNC.
  - Base marker only → latch its code, clear the timer, go to WAIT_V.
  - Variant marker only → latch its code, clear the timer, go to WAIT_B.
- **WAIT_V:**
  - `stall_base=1`. The timer increments each cycle.
  - Variant marker equal to the latched code → paired event, then RUN.
  - Variant marker with a different code → `mismatch`, then DESYNC.
  - Timer reaches TIMEOUT-1 with no marker → `timeout`, then DESYNC.
  - `base_valid` while stalled → set `proto_err`; the commit is otherwise ignored.
  - Non-marker variant commits pass freely.
- **WAIT_B:** mirror of WAIT_V with the roles of the two cores swapped.
- **Paired event:**
  - `evt_valid=1`, `evt_src=2'b11`, `evt_code=code`.
  - START → `phase<=code>>1`, `in_phase<=1`.
  - END → `in_phase<=0` if `code>>1==phase`; otherwise set `proto_err` and leave `phase`/`in_phase` unchanged.
  - `skew_max<=max(skew_max, timer+1)` for barrier waits. A same-cycle pair contributes 0.
- **DESYNC:**
  - No stalls; `sync=0`.
  - Every marker from either core raises `evt_valid`, with `evt_src` set to its core.
  - If both cores commit markers in the same cycle, report base this cycle and variant on the next. This uses a 1-entry variant holding register; if that register is occupied, the new variant marker overwrites it and sets `proto_err`.
  - `phase`/`in_phase` are not updated.
  - `resync` → RUN. The holding register is cleared and sticky flags are kept.
- `resync` has no effect outside DESYNC.
- The timer saturates at all-ones. `skew_max` also saturates.

## Timing
- **Reset values:** state RUN, `sync=1`, stalls 0, `evt_valid=0`, `evt_code=0`, `evt_src=0`, `phase=0`, `in_phase=0`, all flags 0, `skew_max=0`, timer 0.
- **Stalls:** Moore outputs decoded from state. A marker committed in cycle t stalls its core from t+1. On release (other marker at cycle t2), the stall drops at t2+1.
- **Events:**
  - `evt_*`, `phase`, `in_phase` and the flags are registered, visible the cycle after the triggering commit.
  - `evt_valid` is a single-cycle pulse.
- **`sync`:** falls the cycle after DESYNC is entered and rises the cycle after `resync` is sampled.
- **Timeout:** entered in WAIT at cycle t0, with no arrival → DESYNC at t0+TIMEOUT, `timeout` visible the same cycle.
- **Reset mid-wait:** stall drops on the next edge; the latched code and timer are discarded.

## Test plan
- Base commits `0x00002013` at t=10; variant commits the same at t=15 → `stall_base` high on t=11..15, low at 16. One pulse with `evt_src=11`, `evt_code=0`. `phase=0`, `in_phase=1`, `skew_max=5`.
- Both cores commit `0x00402013` in the same cycle → no stall. Event code 4, `phase=2`, `skew_max` unchanged.
- Base commits `0x00602013`; variant commits `0x00802013` → `mismatch=1`, `sync=0`, stall released. A later base marker gives an event with `evt_src=01`.
- TIMEOUT=8; base commits a marker and variant is silent → `timeout=1` and DESYNC 8 cycles after entering WAIT_V. Then a `resync` pulse → `sync=1`, `timeout` still 1.
- In WAIT_V, drive `base_valid` → `proto_err=1`, state stays WAIT_V. Assert `reset` in the next cycle → all outputs return to their reset values.
- DESYNC, both cores commit markers 2 and 3 in the same cycle → two consecutive pulses: code 2 with `evt_src=01`, then code 3 with `evt_src=10`.
